// File: rtl/wb_ibus_dbus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_ibus_dbus_arbiter_if
// Description : Bundle of the core's ibus/dbus request signals and the shared
//               Wishbone-style memory port seen by the ibus/dbus arbiter.
//               "slave" is the arbiter's view. "master" is the view of the
//               surrounding system: the core plus the memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_ibus_dbus_arbiter_if;
  // instruction bus
  logic [31:0] ibus_adr;
  logic        ibus_cyc;
  logic [31:0] ibus_rdt;
  logic        ibus_ack;
  // data bus
  logic [31:0] dbus_adr;
  logic [31:0] dbus_dat;
  logic [3:0]  dbus_sel;
  logic        dbus_we;
  logic        dbus_cyc;
  logic [31:0] dbus_rdt;
  logic        dbus_ack;
  // shared memory port
  logic [31:0] mem_adr;
  logic [31:0] mem_dat;
  logic [3:0]  mem_sel;
  logic        mem_we;
  logic        mem_cyc;
  logic [31:0] mem_rdt;
  logic        mem_ack;

  // Arbiter side: takes core requests and memory responses.
  modport slave (
    input  ibus_adr, ibus_cyc,
    output ibus_rdt, ibus_ack,
    input  dbus_adr, dbus_dat, dbus_sel, dbus_we, dbus_cyc,
    output dbus_rdt, dbus_ack,
    output mem_adr, mem_dat, mem_sel, mem_we, mem_cyc,
    input  mem_rdt, mem_ack
  );

  // System side: the core drives requests, the memory drives responses.
  modport master (
    output ibus_adr, ibus_cyc,
    input  ibus_rdt, ibus_ack,
    output dbus_adr, dbus_dat, dbus_sel, dbus_we, dbus_cyc,
    input  dbus_rdt, dbus_ack,
    input  mem_adr, mem_dat, mem_sel, mem_we, mem_cyc,
    output mem_rdt, mem_ack
  );
endinterface
`default_nettype wire

// File: rtl/wb_ibus_dbus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_ibus_dbus_arbiter
// Description : Merges the core's instruction and data buses onto a single
//               Wishbone-style memory port. One master is granted at a time,
//               simultaneous requests alternate, and a sticky flag records any
//               transaction that waited TIMEOUT cycles without an ack.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_ibus_dbus_arbiter #(
  parameter int TIMEOUT    = 7,
  parameter bit DBUS_FIRST = 1'b1
) (
  input  logic                  clock,
  input  logic                  resetn,
  wb_ibus_dbus_arbiter_if.slave bus,
  output logic                  timeout_err
);

  localparam int             CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  WAIT_MAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  state_t          state;
  logic            last_dbus;   // 1: dbus held the most recent grant
  logic [CW-1:0]   wait_cnt;
  logic [CW-1:0]   wait_next;
  logic            waiting;

  // Saturating next value of the wait counter and the "stalled on memory" flag.
  always_comb begin
    waiting   = bus.mem_cyc & ~bus.mem_ack;
    wait_next = (wait_cnt == WAIT_MAX) ? WAIT_MAX : wait_cnt + 1'b1;
  end

  // Grant FSM, round-robin history, wait counter and sticky timeout flag.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      // Remembering ibus as last winner makes dbus win the first tie.
      last_dbus   <= ~DBUS_FIRST;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (bus.ibus_cyc && bus.dbus_cyc) begin
            state <= last_dbus ? GNT_I : GNT_D;
          end else if (bus.dbus_cyc) begin
            state <= GNT_D;
          end else if (bus.ibus_cyc) begin
            state <= GNT_I;
          end
        end
        GNT_I: begin
          if (bus.mem_ack || !bus.ibus_cyc) begin
            state     <= IDLE;
            last_dbus <= 1'b0;
          end
        end
        GNT_D: begin
          if (bus.mem_ack || !bus.dbus_cyc) begin
            state     <= IDLE;
            last_dbus <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // Only a live, unacked grant counts as waiting; IDLE clears above.
      if (state != IDLE && waiting) begin
        wait_cnt <= wait_next;
        if (wait_next == WAIT_MAX) begin
          timeout_err <= 1'b1;
        end
      end
    end
  end

  // Bus steering: granted master is wired straight through so aborts and acks
  // propagate in the same cycle; everything else is held at zero.
  always_comb begin
    bus.mem_adr  = '0;
    bus.mem_dat  = '0;
    bus.mem_sel  = '0;
    bus.mem_we   = 1'b0;
    bus.mem_cyc  = 1'b0;
    bus.ibus_rdt = '0;
    bus.ibus_ack = 1'b0;
    bus.dbus_rdt = '0;
    bus.dbus_ack = 1'b0;
    unique case (state)
      GNT_I: begin
        bus.mem_cyc  = bus.ibus_cyc;
        bus.mem_adr  = bus.ibus_adr;
        bus.mem_sel  = 4'hF;
        bus.ibus_ack = bus.mem_ack & bus.ibus_cyc;
        bus.ibus_rdt = bus.mem_rdt;
      end
      GNT_D: begin
        bus.mem_cyc  = bus.dbus_cyc;
        bus.mem_adr  = bus.dbus_adr;
        bus.mem_dat  = bus.dbus_dat;
        bus.mem_sel  = bus.dbus_sel;
        bus.mem_we   = bus.dbus_we;
        bus.dbus_ack = bus.mem_ack & bus.dbus_cyc;
        bus.dbus_rdt = bus.mem_rdt;
      end
      default: begin
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_ibus_dbus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_ibus_dbus_arbiter
// Description : Self-checking bench for wb_ibus_dbus_arbiter. A behavioural
//               model tracks who owns the memory port and the timeout flag;
//               directed scenarios are followed by randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_ibus_dbus_arbiter;

  localparam int TIMEOUT    = 7;
  localparam bit DBUS_FIRST = 1'b1;

  logic clock;
  logic resetn;
  logic timeout_err;

  wb_ibus_dbus_arbiter_if bus ();

  wb_ibus_dbus_arbiter #(
    .TIMEOUT    (TIMEOUT),
    .DBUS_FIRST (DBUS_FIRST)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .bus         (bus),
    .timeout_err (timeout_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: owner of the port (0 none, 1 ibus, 2 dbus), who won last,
  // consecutive unacked cycles of the current grant and the sticky flag.
  int owner;
  bit last_was_d;
  int stall;
  bit err_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    owner      = 0;
    last_was_d = !DBUS_FIRST;
    stall      = 0;
    err_m      = 1'b0;
  endtask

  // Compare every DUT output against what the model says it must be now.
  task automatic model_check();
    logic [31:0] e_adr, e_dat, e_irdt, e_drdt;
    logic [3:0]  e_sel;
    logic        e_we, e_cyc, e_iack, e_dack;
    e_adr = 0; e_dat = 0; e_sel = 0; e_we = 0; e_cyc = 0;
    e_iack = 0; e_dack = 0; e_irdt = 0; e_drdt = 0;
    if (owner == 1) begin
      e_cyc  = bus.ibus_cyc;
      e_adr  = bus.ibus_adr;
      e_sel  = 4'hF;
      e_iack = bus.mem_ack && bus.ibus_cyc;
      e_irdt = bus.mem_rdt;
    end else if (owner == 2) begin
      e_cyc  = bus.dbus_cyc;
      e_adr  = bus.dbus_adr;
      e_dat  = bus.dbus_dat;
      e_sel  = bus.dbus_sel;
      e_we   = bus.dbus_we;
      e_dack = bus.mem_ack && bus.dbus_cyc;
      e_drdt = bus.mem_rdt;
    end
    check("mem_cyc",     32'(bus.mem_cyc),  32'(e_cyc));
    check("mem_adr",     bus.mem_adr,       e_adr);
    check("mem_dat",     bus.mem_dat,       e_dat);
    check("mem_sel",     32'(bus.mem_sel),  32'(e_sel));
    check("mem_we",      32'(bus.mem_we),   32'(e_we));
    check("ibus_ack",    32'(bus.ibus_ack), 32'(e_iack));
    check("ibus_rdt",    bus.ibus_rdt,      e_irdt);
    check("dbus_ack",    32'(bus.dbus_ack), 32'(e_dack));
    check("dbus_rdt",    bus.dbus_rdt,      e_drdt);
    check("timeout_err", 32'(timeout_err),  32'(err_m));
  endtask

  // Model transition for the clock edge, from the inputs presented this cycle.
  task automatic model_step();
    bit own_cyc;
    if (owner == 0) begin
      stall = 0;
      if (bus.ibus_cyc && bus.dbus_cyc) owner = last_was_d ? 1 : 2;
      else if (bus.dbus_cyc)            owner = 2;
      else if (bus.ibus_cyc)            owner = 1;
    end else begin
      own_cyc = (owner == 1) ? bus.ibus_cyc : bus.dbus_cyc;
      if (own_cyc && !bus.mem_ack) begin
        stall = (stall < TIMEOUT) ? stall + 1 : TIMEOUT;
        if (stall == TIMEOUT) err_m = 1'b1;
      end
      if (bus.mem_ack || !own_cyc) begin
        last_was_d = (owner == 2);
        owner      = 0;
      end
    end
  endtask

  // Inputs are driven at posedge+1; outputs are sampled on the falling edge.
  task automatic settle();
    @(negedge clock);
    model_check();
  endtask

  task automatic advance();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic cycle();
    settle();
    advance();
  endtask

  task automatic idle_inputs();
    bus.ibus_adr = 0; bus.ibus_cyc = 0;
    bus.dbus_adr = 0; bus.dbus_dat = 0; bus.dbus_sel = 0; bus.dbus_we = 0; bus.dbus_cyc = 0;
    bus.mem_rdt  = 0; bus.mem_ack  = 0;
  endtask

  // Asynchronous reset pulse: outputs must clear before any clock edge.
  task automatic pulse_reset();
    resetn = 1'b0;
    #1;
    model_reset();
    check("rst_mem_cyc",  32'(bus.mem_cyc),  32'd0);
    check("rst_mem_adr",  bus.mem_adr,       32'd0);
    check("rst_ibus_ack", 32'(bus.ibus_ack), 32'd0);
    check("rst_dbus_ack", 32'(bus.dbus_ack), 32'd0);
    check("rst_ibus_rdt", bus.ibus_rdt,      32'd0);
    check("rst_dbus_rdt", bus.dbus_rdt,      32'd0);
    check("rst_tmo",      32'(timeout_err),  32'd0);
    @(posedge clock);
    #1;
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b1;
    cycle();

    // ibus-only fetch from 0x100
    bus.ibus_cyc = 1; bus.ibus_adr = 32'h100;
    cycle();
    settle();
    check("fetch_cyc", 32'(bus.mem_cyc), 32'd1);
    check("fetch_adr", bus.mem_adr, 32'h100);
    check("fetch_sel", 32'(bus.mem_sel), 32'hF);
    advance();
    bus.mem_ack = 1; bus.mem_rdt = 32'h13;
    settle();
    check("fetch_ack", 32'(bus.ibus_ack), 32'd1);
    check("fetch_rdt", bus.ibus_rdt, 32'h13);
    advance();
    idle_inputs();
    settle();
    check("fetch_idle", 32'(bus.mem_cyc), 32'd0);
    advance();

    // dbus store
    bus.dbus_cyc = 1; bus.dbus_adr = 32'h2000; bus.dbus_dat = 32'hDEADBEEF;
    bus.dbus_sel = 4'b0011; bus.dbus_we = 1;
    cycle();
    settle();
    check("st_adr", bus.mem_adr, 32'h2000);
    check("st_dat", bus.mem_dat, 32'hDEADBEEF);
    check("st_sel", 32'(bus.mem_sel), 32'h3);
    check("st_we",  32'(bus.mem_we), 32'd1);
    advance();
    bus.mem_ack = 1;
    settle();
    check("st_dack", 32'(bus.dbus_ack), 32'd1);
    check("st_iack", 32'(bus.ibus_ack), 32'd0);
    advance();
    idle_inputs();

    // simultaneous requests right after reset
    pulse_reset();
    bus.ibus_cyc = 1; bus.ibus_adr = 32'h400;
    bus.dbus_cyc = 1; bus.dbus_adr = 32'h800;
    cycle();
    settle();
    check("tie1_d", bus.mem_adr, 32'h800);
    advance();
    bus.mem_ack = 1;
    cycle();
    bus.mem_ack = 0; bus.dbus_cyc = 0;
    settle();
    check("tie_gap", 32'(bus.mem_cyc), 32'd0);
    advance();
    settle();
    check("tie2_i", bus.mem_adr, 32'h400);
    advance();
    bus.mem_ack = 1;
    cycle();
    bus.mem_ack = 0; bus.dbus_cyc = 1;
    cycle();
    settle();
    check("tie3_d", bus.mem_adr, 32'h800);
    advance();

    // abort in GNT_D, then a late ack
    bus.ibus_cyc = 0;
    cycle();
    bus.dbus_cyc = 0;
    settle();
    check("abort_cyc", 32'(bus.mem_cyc), 32'd0);
    advance();
    bus.mem_ack = 1;
    settle();
    check("late_dack", 32'(bus.dbus_ack), 32'd0);
    check("late_iack", 32'(bus.ibus_ack), 32'd0);
    advance();
    idle_inputs();

    // timeout: 7 waiting cycles
    pulse_reset();
    bus.dbus_cyc = 1; bus.dbus_adr = 32'h40;
    cycle();
    for (int i = 0; i < TIMEOUT; i++) begin
      settle();
      check("tmo_pre", 32'(timeout_err), 32'd0);
      advance();
    end
    settle();
    check("tmo_set", 32'(timeout_err), 32'd1);
    advance();
    bus.mem_ack = 1;
    cycle();
    idle_inputs();
    settle();
    check("tmo_sticky", 32'(timeout_err), 32'd1);
    advance();
    pulse_reset();
    settle();
    check("tmo_clr", 32'(timeout_err), 32'd0);
    advance();

    // reset while ibus is granted
    bus.ibus_cyc = 1; bus.ibus_adr = 32'h77C;
    cycle();
    settle();
    check("mid_gnt", 32'(bus.mem_cyc), 32'd1);
    pulse_reset();
    idle_inputs();
    bus.ibus_cyc = 1; bus.dbus_cyc = 1; bus.dbus_adr = 32'h99;
    cycle();
    settle();
    check("mid_after", bus.mem_adr, 32'h99);
    advance();
    idle_inputs();
    cycle();

    // randomized traffic, with memory stalls and occasional resets
    for (int n = 0; n < 3000; n++) begin
      bus.ibus_cyc = ($urandom_range(0, 9) < 6);
      bus.dbus_cyc = ($urandom_range(0, 9) < 6);
      bus.ibus_adr = $urandom;
      bus.dbus_adr = $urandom;
      bus.dbus_dat = $urandom;
      bus.dbus_sel = 4'($urandom);
      bus.dbus_we  = 1'($urandom);
      bus.mem_rdt  = $urandom;
      bus.mem_ack  = ((n % 300) < 260) && ($urandom_range(0, 9) < 4);
      if ($urandom_range(0, 199) == 0) begin
        pulse_reset();
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
